// File: rtl/out_bus_arbiter.sv
// out_bus_arbiter
// Shares the executor output-register/strobe bus between two requesters:
// requester 0 (s3g_executor, host commands) and requester 1 (buf_executor,
// FIFO program). A grant covers a whole burst, so an OUTPUT...STB sequence
// from one requester is never interleaved with the other. Simultaneous
// requests are resolved round-robin. A watchdog takes the bus back from an
// owner that stays idle for TIMEOUT cycles, and bars that owner until it
// drops its request.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   rqK_req                bus request, held for the whole burst
//   rqK_addr/data          register address / data of a beat
//   rqK_wr, rqK_stb        write strobe / strobe bits (one beat per cycle)
//   rqK_gnt                registered grant
//   rqK_ack                one-cycle pulse per accepted beat
//   out_addr/out_data      shared bus address/data (held between beats)
//   out_wr, out_stb        shared write pulse / strobe pulses
//   owner                  index of the last or current grantee
//   timeout_err            one-cycle pulse on a watchdog release
module out_bus_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int STB_WIDTH  = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rq0_req,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [DATA_WIDTH-1:0] rq0_data,
    input  logic                  rq0_wr,
    input  logic [STB_WIDTH-1:0]  rq0_stb,
    input  logic                  rq1_req,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [DATA_WIDTH-1:0] rq1_data,
    input  logic                  rq1_wr,
    input  logic [STB_WIDTH-1:0]  rq1_stb,
    output logic                  rq0_gnt,
    output logic                  rq1_gnt,
    output logic                  rq0_ack,
    output logic                  rq1_ack,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_wr,
    output logic [STB_WIDTH-1:0]  out_stb,
    output logic                  owner,
    output logic                  timeout_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t          state;
    logic            rr_last;
    logic [CW-1:0]   wd_cnt;
    logic            bar0, bar1;

    logic            elig0, elig1;
    logic            cur_sel;
    logic            cur_req, cur_gnt, cur_wr, beat;
    logic [STB_WIDTH-1:0]  cur_stb;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;

    // Both grant states share one datapath; cur_sel picks the owner's inputs.
    always_comb begin
        elig0    = rq0_req & ~bar0;
        elig1    = rq1_req & ~bar1;
        cur_sel  = (state == GNT1);
        cur_req  = cur_sel ? rq1_req  : rq0_req;
        cur_gnt  = cur_sel ? rq1_gnt  : rq0_gnt;
        cur_wr   = cur_sel ? rq1_wr   : rq0_wr;
        cur_stb  = cur_sel ? rq1_stb  : rq0_stb;
        cur_addr = cur_sel ? rq1_addr : rq0_addr;
        cur_data = cur_sel ? rq1_data : rq0_data;
        beat     = cur_gnt & (cur_wr | (|cur_stb));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_last     <= 1'b1;
            wd_cnt      <= '0;
            bar0        <= 1'b0;
            bar1        <= 1'b0;
            rq0_gnt     <= 1'b0;
            rq1_gnt     <= 1'b0;
            rq0_ack     <= 1'b0;
            rq1_ack     <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
            out_wr      <= 1'b0;
            out_stb     <= '0;
            owner       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            out_wr      <= 1'b0;
            out_stb     <= '0;
            rq0_ack     <= 1'b0;
            rq1_ack     <= 1'b0;
            timeout_err <= 1'b0;
            if (!rq0_req) bar0 <= 1'b0;
            if (!rq1_req) bar1 <= 1'b0;

            case (state)
                IDLE: begin
                    // rr_last=1 means requester 1 went last, so 0 wins a tie.
                    if (elig0 && (!elig1 || rr_last)) begin
                        state   <= GNT0;
                        rq0_gnt <= 1'b1;
                        rr_last <= 1'b0;
                        owner   <= 1'b0;
                        wd_cnt  <= '0;
                    end else if (elig1) begin
                        state   <= GNT1;
                        rq1_gnt <= 1'b1;
                        rr_last <= 1'b1;
                        owner   <= 1'b1;
                        wd_cnt  <= '0;
                    end
                end

                GNT0, GNT1: begin
                    // A beat in the release cycle is still forwarded.
                    if (beat) begin
                        out_addr <= cur_addr;
                        out_data <= cur_data;
                        out_wr   <= cur_wr;
                        out_stb  <= cur_stb;
                        if (cur_sel) rq1_ack <= 1'b1;
                        else         rq0_ack <= 1'b1;
                    end

                    if (!cur_req) begin
                        state   <= IDLE;
                        rq0_gnt <= 1'b0;
                        rq1_gnt <= 1'b0;
                        wd_cnt  <= '0;
                    end else if (beat) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        state       <= IDLE;
                        rq0_gnt     <= 1'b0;
                        rq1_gnt     <= 1'b0;
                        timeout_err <= 1'b1;
                        if (cur_sel) bar1 <= 1'b1;
                        else         bar0 <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_bus_arbiter.sv
module tb_out_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rq0_req, rq1_req;
    logic [5:0]  rq0_addr, rq1_addr;
    logic [31:0] rq0_data, rq1_data;
    logic        rq0_wr, rq1_wr;
    logic [31:0] rq0_stb, rq1_stb;
    logic        rq0_gnt, rq1_gnt, rq0_ack, rq1_ack;
    logic [5:0]  out_addr;
    logic [31:0] out_data;
    logic        out_wr;
    logic [31:0] out_stb;
    logic        owner, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    out_bus_arbiter #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(32),
        .STB_WIDTH (32),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rq0_req    (rq0_req),
        .rq0_addr   (rq0_addr),
        .rq0_data   (rq0_data),
        .rq0_wr     (rq0_wr),
        .rq0_stb    (rq0_stb),
        .rq1_req    (rq1_req),
        .rq1_addr   (rq1_addr),
        .rq1_data   (rq1_data),
        .rq1_wr     (rq1_wr),
        .rq1_stb    (rq1_stb),
        .rq0_gnt    (rq0_gnt),
        .rq1_gnt    (rq1_gnt),
        .rq0_ack    (rq0_ack),
        .rq1_ack    (rq1_ack),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_wr     (out_wr),
        .out_stb    (out_stb),
        .owner      (owner),
        .timeout_err(timeout_err)
    );

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rq0_req = 0; rq0_addr = '0; rq0_data = '0; rq0_wr = 0; rq0_stb = '0;
        rq1_req = 0; rq1_addr = '0; rq1_data = '0; rq1_wr = 0; rq1_stb = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({rq0_gnt, rq1_gnt, rq0_ack, rq1_ack} !== 4'b0) begin errors++; $display("FAIL reset_gnt_ack got %b want 0000", {rq0_gnt, rq1_gnt, rq0_ack, rq1_ack}); end
        checks++; if ({out_wr, out_stb, out_addr, out_data} !== '0) begin errors++; $display("FAIL reset_bus got wr=%b stb=%h addr=%h data=%h want 0", out_wr, out_stb, out_addr, out_data); end
        checks++; if ({owner, timeout_err} !== 2'b00) begin errors++; $display("FAIL reset_owner_to got %b want 00", {owner, timeout_err}); end
    endtask

    task automatic test_single_grant();
        do_reset();
        rq1_req = 1;
        tick();
        checks++; if ({rq0_gnt, rq1_gnt, owner} !== 3'b011) begin errors++; $display("FAIL sg_grant got g0,g1,own=%b want 011", {rq0_gnt, rq1_gnt, owner}); end
        rq1_wr = 1; rq1_addr = 6'd0; rq1_data = 32'd1000;
        tick();
        checks++; if ({out_wr, rq1_ack, rq0_ack} !== 3'b110) begin errors++; $display("FAIL sg_beat got wr,ack1,ack0=%b want 110", {out_wr, rq1_ack, rq0_ack}); end
        checks++; if (out_addr !== 6'd0 || out_data !== 32'd1000) begin errors++; $display("FAIL sg_data got addr=%0d data=%0d want 0 1000", out_addr, out_data); end
        rq1_wr = 0;
        tick();
        checks++; if ({out_wr, rq1_ack} !== 2'b00 || out_data !== 32'd1000) begin errors++; $display("FAIL sg_pulse got wr,ack=%b data=%0d want 00 1000", {out_wr, rq1_ack}, out_data); end
        rq1_req = 0;
        tick();
        checks++; if (rq1_gnt !== 1'b0 || owner !== 1'b1) begin errors++; $display("FAIL sg_release got gnt=%b own=%b want 0 1", rq1_gnt, owner); end
    endtask

    task automatic test_tie_rr();
        do_reset();
        rq0_req = 1; rq1_req = 1;
        tick();
        checks++; if ({rq0_gnt, rq1_gnt, owner} !== 3'b100) begin errors++; $display("FAIL tie1 got g0,g1,own=%b want 100", {rq0_gnt, rq1_gnt, owner}); end
        tick();
        rq0_req = 0;
        tick();
        checks++; if ({rq0_gnt, rq1_gnt} !== 2'b00) begin errors++; $display("FAIL tie_dead got g0,g1=%b want 00", {rq0_gnt, rq1_gnt}); end
        tick();
        checks++; if ({rq0_gnt, rq1_gnt, owner} !== 3'b011) begin errors++; $display("FAIL tie_rr got g0,g1,own=%b want 011", {rq0_gnt, rq1_gnt, owner}); end
        rq1_req = 0;
        tick();
        rq0_req = 1; rq1_req = 1;
        tick();
        checks++; if ({rq0_gnt, rq1_gnt, owner} !== 3'b100) begin errors++; $display("FAIL tie2 got g0,g1,own=%b want 100", {rq0_gnt, rq1_gnt, owner}); end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_burst();
        logic [5:0]  addrs [8];
        logic [31:0] datas [8];
        addrs = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7, 6'd7};
        datas = '{32'd1000, 32'd100, 32'd16, 32'd16, 32'd32, 32'd48, 32'h888888, 32'h888888};
        do_reset();
        rq1_req = 1;
        tick();
        checks++; if (rq1_gnt !== 1'b1) begin errors++; $display("FAIL burst_gnt got %b want 1", rq1_gnt); end
        for (int i = 0; i < 8; i++) begin
            rq1_addr = addrs[i];
            rq1_data = datas[i];
            rq1_wr   = (i < 7);
            rq1_stb  = (i == 7) ? 32'h10 : 32'h0;
            if (i == 2) rq0_req = 1;
            tick();
            checks++;
            if (out_wr !== (i < 7) || out_stb !== ((i == 7) ? 32'h10 : 32'h0) || out_addr !== addrs[i] ||
                out_data !== datas[i] || rq1_ack !== 1'b1 || rq0_gnt !== 1'b0) begin
                errors++;
                $display("FAIL burst_beat%0d got wr=%b stb=%h addr=%0d data=%h ack1=%b g0=%b want wr=%b stb=%h addr=%0d data=%h ack1=1 g0=0",
                         i, out_wr, out_stb, out_addr, out_data, rq1_ack, rq0_gnt,
                         (i < 7), ((i == 7) ? 32'h10 : 32'h0), addrs[i], datas[i]);
            end
        end
        rq1_wr = 0; rq1_stb = '0; rq1_req = 0;
        tick();
        checks++; if ({rq0_gnt, rq1_gnt, out_wr, out_stb} !== '0) begin errors++; $display("FAIL burst_drop got g0=%b g1=%b wr=%b stb=%h want all 0", rq0_gnt, rq1_gnt, out_wr, out_stb); end
        tick();
        checks++; if ({rq0_gnt, owner} !== 2'b10) begin errors++; $display("FAIL burst_handover got g0,own=%b want 10", {rq0_gnt, owner}); end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_ignored();
        do_reset();
        rq0_wr = 1; rq0_addr = 6'd9; rq0_data = 32'hdead;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({out_wr, rq0_ack, rq0_gnt} !== 3'b000 || out_data !== 32'h0) begin errors++; $display("FAIL ignored%0d got wr,ack,gnt=%b data=%h want 000 0", i, {out_wr, rq0_ack, rq0_gnt}, out_data); end
        end
        clear_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        rq0_req = 1;
        tick();
        checks++; if (rq0_gnt !== 1'b1) begin errors++; $display("FAIL wd_gnt got %b want 1", rq0_gnt); end
        rq1_req = 1;
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++; if ({timeout_err, rq0_gnt} !== 2'b01) begin errors++; $display("FAIL wd_wait%0d got to,g0=%b want 01", i, {timeout_err, rq0_gnt}); end
        end
        tick();
        checks++; if ({timeout_err, rq0_gnt, rq1_gnt} !== 3'b100) begin errors++; $display("FAIL wd_fire got to,g0,g1=%b want 100", {timeout_err, rq0_gnt, rq1_gnt}); end
        tick();
        checks++; if ({timeout_err, rq1_gnt, owner} !== 3'b011) begin errors++; $display("FAIL wd_other got to,g1,own=%b want 011", {timeout_err, rq1_gnt, owner}); end
        rq1_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({rq0_gnt, rq1_gnt} !== 2'b00) begin errors++; $display("FAIL wd_barred%0d got g0,g1=%b want 00", i, {rq0_gnt, rq1_gnt}); end
        end
        rq0_req = 0;
        tick();
        rq0_req = 1;
        tick();
        checks++; if ({rq0_gnt, owner} !== 2'b10) begin errors++; $display("FAIL wd_regrant got g0,own=%b want 10", {rq0_gnt, owner}); end
        clear_inputs();
        tick();
    endtask

    task automatic test_watchdog_beat();
        do_reset();
        rq0_req = 1;
        tick();
        for (int i = 1; i < 16; i++) tick();
        // Counter now at TIMEOUT-1: a beat in this cycle must win.
        rq0_wr = 1; rq0_addr = 6'd3; rq0_data = 32'h55;
        tick();
        checks++; if ({timeout_err, rq0_gnt, out_wr, rq0_ack} !== 4'b0111 || out_data !== 32'h55) begin errors++; $display("FAIL wdb_beat got to,g0,wr,ack=%b data=%h want 0111 55", {timeout_err, rq0_gnt, out_wr, rq0_ack}, out_data); end
        rq0_wr = 0;
        for (int i = 1; i < 16; i++) tick();
        checks++; if ({timeout_err, rq0_gnt} !== 2'b01) begin errors++; $display("FAIL wdb_restart got to,g0=%b want 01", {timeout_err, rq0_gnt}); end
        tick();
        checks++; if ({timeout_err, rq0_gnt} !== 2'b10) begin errors++; $display("FAIL wdb_fire got to,g0=%b want 10", {timeout_err, rq0_gnt}); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rq1_req = 1;
        tick();
        rq1_wr = 1; rq1_addr = 6'd5; rq1_data = 32'h1234;
        rst = 1;
        tick();
        checks++; if ({out_wr, rq1_ack, rq1_gnt} !== 3'b000 || out_data !== 32'h0) begin errors++; $display("FAIL rmid got wr,ack,gnt=%b data=%h want 000 0", {out_wr, rq1_ack, rq1_gnt}, out_data); end
        rst = 0;
        clear_inputs();
        tick();
        checks++; if ({rq0_gnt, rq1_gnt, out_wr} !== 3'b000) begin errors++; $display("FAIL rmid_idle got g0,g1,wr=%b want 000", {rq0_gnt, rq1_gnt, out_wr}); end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single_grant();
        test_tie_rr();
        test_burst();
        test_ignored();
        test_watchdog();
        test_watchdog_beat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_bus_arbiter.md
Name: out_bus_arbiter

Overview:
- Shares the executor output-register/strobe bus (OUTPUT n/value writes, STB bit pulses) between two requesters: requester 0 = s3g_executor (host commands), requester 1 = buf_executor (FIFO program).
- Grants whole bursts, so that an OUTPUT…STB sequence from one requester is never interleaved with the other.
- Round-robin between simultaneous requests.
- Idle-watchdog reclaims the bus from a stalled owner.

Parameters:
- ADDR_WIDTH, 6, output register address width
- DATA_WIDTH, 32, output register data width
- STB_WIDTH, 32, number of strobe lines
- TIMEOUT, 1024, idle cycles of a granted owner before forced release (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rq0_req / rq1_req  in  1  bus request, held for the whole burst
- rq0_addr / rq1_addr  in  ADDR_WIDTH  register address
- rq0_data / rq1_data  in  DATA_WIDTH  register data
- rq0_wr / rq1_wr  in  1  write strobe, one beat per cycle
- rq0_stb / rq1_stb  in  STB_WIDTH  strobe bits to pulse
- rq0_gnt / rq1_gnt  out  1  grant, registered
- rq0_ack / rq1_ack  out  1  beat accepted, one-cycle pulse
- out_addr  out  ADDR_WIDTH  shared bus address
- out_data  out  DATA_WIDTH  shared bus data
- out_wr  out  1  shared write pulse
- out_stb  out  STB_WIDTH  shared strobe pulses
- owner  out  1  index of last/current grantee
- timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- **Reset (rst=1 at clk edge):**
  - All outputs 0; owner=0; state IDLE.
  - Internal rr_last=1, so requester 0 wins the first tie.
  - Watchdog counter 0; both bar flags cleared.
  - Reset mid-burst aborts the grant silently: no ack, no out_wr.
- **States:** IDLE, GNT0, GNT1.
- **IDLE:**
  - Eligible requester k = rqk_req & ~bark.
  - One eligible → next state GNTk, rqk_gnt=1 on that edge (1-cycle req→gnt latency).
  - Both eligible → grant the one ≠ rr_last.
  - On each grant: rr_last←k, owner←k.
- **GNTk:**
  - Stays while rqk_req=1. The other requester's request waits, with no preemption.
  - Beat: cycle with rqk_gnt=1 and (rqk_wr=1 or rqk_stb≠0). On the next edge:
    - out_addr/out_data ← rqk_addr/rqk_data.
    - out_wr ← rqk_wr.
    - out_stb ← rqk_stb.
    - rqk_ack=1.
  - All of these are one-cycle pulses. out_addr/out_data hold their last value otherwise.
  - Back-to-back beats are allowed every cycle; throughput is 1 beat/cycle.
  - wr and stb in the same cycle are both forwarded in the same output cycle.
  - rqk_req=0 → next edge: gnt=0, state IDLE. A beat presented in that same cycle is still forwarded and acked, since gnt was high.
  - Non-owner wr/stb, and any wr/stb while gnt=0: ignored, no ack, no output.
- **Handover:** at least one dead cycle (IDLE) between release by one requester and grant to the other.
- **Watchdog:**
  - Counter resets to 0 on grant and on each beat; increments every cycle in GNTk with no beat.
  - Counter reaching TIMEOUT-1 with no beat → next edge: gnt=0, state IDLE, timeout_err=1 for one cycle, bark=1.
  - bark clears when rqk_req is seen 0. A barred requester is not granted while barred.
  - Counter width is $clog2(TIMEOUT)+1. It never wraps: it saturates at the timeout event.
- **Simultaneous events:**
  - Owner release and other-request in the same cycle → IDLE, then grant on the following edge.
  - Timeout and beat in the same cycle → beat wins, counter cleared, no timeout.
- No combinational path from rq*_req to rq*_gnt or out_*. All outputs are registered.

Test Plan:
- **Reset, then single grant:** rst 2 cycles; rq1_req=1 at cycle 5 → rq1_gnt=1 at cycle 6, owner=1. Then rq1_wr with addr=0, data=1000 at cycle 7 → out_wr=1, out_addr=0, out_data=1000, rq1_ack=1 at cycle 8 only.
- **Tie and round-robin:**
  - Both req at cycle 5 after reset → rq0_gnt at cycle 6.
  - rq0 drops at cycle 8 → IDLE at cycle 9, rq1_gnt at cycle 10.
  - Repeat tie → requester 0 wins again, because rr_last=1.
- **Burst atomicity:** rq1 granted, sends 7 writes (addr 0..5, 7; data 1000, 100, 16, 16, 32, 48, 0x888888) back-to-back plus stb=0x10. rq0_req raised mid-burst → all 8 beats appear in order on consecutive cycles; rq0_gnt stays 0 until 2 cycles after rq1_req drops.
- **Ignored writes:** rq0_wr=1 with rq0_gnt=0 for 5 cycles → out_wr=0, rq0_ack=0 throughout.
- **Watchdog (TIMEOUT=16):** rq0 granted, no beats → timeout_err=1 exactly 16 cycles after grant. rq0_gnt=0; rq1_req pending is granted 1 cycle later. rq0 keeps req=1 → never regranted until it drops req for ≥1 cycle.
- **Reset mid-burst:** rst asserted at the cycle of rq1_wr → next cycle out_wr=0, rq1_ack=0, rq1_gnt=0, state IDLE.
